lif_chain: RTL and testbench

//  Parametrised chain of N leaky-integrate-and-fire neurons. Neuron 0 integrates an external

---
 rtl/lif_pkg.sv | 23 ++
 rtl/lif_chain_if.sv | 28 ++
 rtl/lif_neuron_cell.sv | 105 ++++++++++
 rtl/lif_chain.sv | 90 +++++++++
 tb/tb_lif_chain.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared types and the saturating leak/integrate helper for the LIF neuron chain.
package lif_pkg;

  typedef enum logic {
    LIF_INTEGRATE,
    LIF_REFRACTORY
  } lif_state_e;

  localparam int REFRAC_W = 4;

  // Returns the leaked membrane plus input, clamped to 2**width-1.
  function automatic logic [31:0] lif_leak_add(input logic [31:0] state,
                                               input logic [31:0] in,
                                               input int unsigned shift,
                                               input int unsigned width);
    logic [32:0] s;
    logic [31:0] maxv;
    s    = {1'b0, state - (state >> shift)} + {1'b0, in};
    maxv = 32'hFFFF_FFFF >> (32 - width);
    return (s > {1'b0, maxv}) ? maxv : s[31:0];
  endfunction

endpackage

// File: rtl/lif_chain_if.sv
// Control/readout bundle of the LIF chain; LIF_SPIKE_COUNT_EN adds the spike-counter signals.
interface lif_chain_if #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 2
);
  localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                 en;
  logic [WIDTH-1:0]     current_in;
  logic [WIDTH-1:0]     threshold;
  logic [SEL_W-1:0]     sel;
  logic [N_NEURONS-1:0] spike;
  logic [WIDTH-1:0]     state_out;
`ifdef LIF_SPIKE_COUNT_EN
  logic                 cnt_clr;
  logic [15:0]          spike_cnt;

  modport master(output en, current_in, threshold, sel, cnt_clr,
                 input  spike, state_out, spike_cnt);
  modport slave (input  en, current_in, threshold, sel, cnt_clr,
                 output spike, state_out, spike_cnt);
`else
  modport master(output en, current_in, threshold, sel,
                 input  spike, state_out);
  modport slave (input  en, current_in, threshold, sel,
                 output spike, state_out);
`endif
endinterface

// File: rtl/lif_neuron_cell.sv
// One leaky-integrate-and-fire neuron: membrane, refractory FSM/counter and,
// under LIF_SPIKE_COUNT_EN, a saturating 16-bit spike counter.
module lif_neuron_cell
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] cur_in,
  input  logic [WIDTH-1:0] threshold,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic             cnt_clr,
  output logic [15:0]      cnt_o,
`endif
  output logic [WIDTH-1:0] mem_o,
  output logic             spike_o
);

  lif_state_e            fsm_q, fsm_d;
  logic [REFRAC_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]      mem_q, mem_d;
  logic                  spike_q, spike_d;
  logic [31:0]           sum;
  logic                  fire;

  always_comb begin
    sum  = lif_leak_add(32'(mem_q), 32'(cur_in), LEAK_SHIFT, WIDTH);
    fire = (threshold != '0) && (sum >= 32'(threshold));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= LIF_INTEGRATE;
      cnt_q   <= '0;
      mem_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      spike_q <= spike_d;
    end
  end

  // Refractory exit happens on the edge that consumes the last count.
  always_comb begin
    fsm_d = fsm_q;
    if (en) begin
      case (fsm_q)
        LIF_INTEGRATE:  if (fire && (REFRAC != 0)) fsm_d = LIF_REFRACTORY;
        LIF_REFRACTORY: if (cnt_q == REFRAC_W'(1)) fsm_d = LIF_INTEGRATE;
        default:        fsm_d = LIF_INTEGRATE;
      endcase
    end
  end

  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    if (en) begin
      case (fsm_q)
        LIF_INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            mem_d   = '0;
            cnt_d   = REFRAC_W'(REFRAC);
          end else begin
            mem_d = sum[WIDTH-1:0];
          end
        end
        default: begin
          mem_d = '0;
          cnt_d = cnt_q - REFRAC_W'(1);
        end
      endcase
    end
  end

  assign mem_o   = mem_q;
  assign spike_o = spike_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] scnt_q, scnt_d;

  // Clear wins over a coincident spike.
  always_comb begin
    scnt_d = scnt_q;
    if (cnt_clr)                           scnt_d = '0;
    else if (spike_d && scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt_q <= '0;
    else        scnt_q <= scnt_d;
  end

  assign cnt_o = scnt_q;
`endif

endmodule

// File: rtl/lif_chain.sv
// Chain of N LIF neurons with spike-driven synapses and a registered readout mux.
// Optional LIF_SPIKE_COUNT_EN adds per-neuron spike counters and cnt_clr/spike_cnt.
module lif_chain
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int N_NEURONS  = 2,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int SYN_WEIGHT = 255
) (
  input logic       clk,
  input logic       rst_n,
  lif_chain_if.slave bus
);

  logic [WIDTH-1:0]     mem [N_NEURONS];
  logic [N_NEURONS-1:0] spike_w;
  logic [WIDTH-1:0]     state_out_q, state_out_d;
`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0]          cnt [N_NEURONS];
  logic [15:0]          spike_cnt_q, spike_cnt_d;
`endif

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_cell
    logic [WIDTH-1:0] cell_in;

    // Downstream neurons see the registered spike of their predecessor: one cycle per hop.
    if (k == 0) begin : g_head
      assign cell_in = bus.current_in;
    end else begin : g_link
      assign cell_in = spike_w[k-1] ? WIDTH'(SYN_WEIGHT) : '0;
    end

    lif_neuron_cell #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (bus.en),
      .cur_in    (cell_in),
      .threshold (bus.threshold),
`ifdef LIF_SPIKE_COUNT_EN
      .cnt_clr   (bus.cnt_clr),
      .cnt_o     (cnt[k]),
`endif
      .mem_o     (mem[k]),
      .spike_o   (spike_w[k])
    );
  end

  // Readout keeps tracking sel even while stepping is disabled.
  always_comb begin
    state_out_d = '0;
`ifdef LIF_SPIKE_COUNT_EN
    spike_cnt_d = '0;
`endif
    for (int k = 0; k < N_NEURONS; k++) begin
      if (int'(bus.sel) == k) begin
        state_out_d = mem[k];
`ifdef LIF_SPIKE_COUNT_EN
        spike_cnt_d = cnt[k];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_out_q <= '0;
`ifdef LIF_SPIKE_COUNT_EN
      spike_cnt_q <= '0;
`endif
    end else begin
      state_out_q <= state_out_d;
`ifdef LIF_SPIKE_COUNT_EN
      spike_cnt_q <= spike_cnt_d;
`endif
    end
  end

  assign bus.spike     = spike_w;
  assign bus.state_out = state_out_q;
`ifdef LIF_SPIKE_COUNT_EN
  assign bus.spike_cnt = spike_cnt_q;
`endif

endmodule

// File: tb/tb_lif_chain.sv
// Bench for lif_chain: hand-computed vector table, reset/counter sequences and a
// randomized run against a behavioural model of the neuron chain.
module tb_lif_chain;
  localparam int W   = 8;
  localparam int NN  = 2;
  localparam int LS  = 1;
  localparam int RF  = 2;
  localparam int SYN = 255;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lif_chain_if #(.WIDTH(W), .N_NEURONS(NN)) bus();

  lif_chain #(.WIDTH(W), .N_NEURONS(NN), .LEAK_SHIFT(LS), .REFRAC(RF), .SYN_WEIGHT(SYN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: blk counts remaining edges on which the neuron is blocked.
  int m_mem [NN];
  int m_blk [NN];
  int m_spk [NN];
  int m_cnt [NN];
  int m_so, m_cnto, m_spkvec;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NN; k++) begin
      m_mem[k] = 0; m_blk[k] = 0; m_spk[k] = 0; m_cnt[k] = 0;
    end
    m_so = 0; m_cnto = 0; m_spkvec = 0;
  endtask

  task automatic model_step();
    int om [NN];
    int os [NN];
    int oc [NN];
    int s, inp, clr;
    om = m_mem; os = m_spk; oc = m_cnt;
    m_so   = (int'(bus.sel) < NN) ? om[bus.sel] : 0;
    m_cnto = (int'(bus.sel) < NN) ? oc[bus.sel] : 0;
`ifdef LIF_SPIKE_COUNT_EN
    clr = int'(bus.cnt_clr);
`else
    clr = 0;
`endif
    for (int k = 0; k < NN; k++) begin
      if (!bus.en) begin
        m_spk[k] = 0;
      end else begin
        if (k == 0) inp = int'(bus.current_in);
        else        inp = (os[k-1] != 0) ? SYN : 0;
        if (m_blk[k] > 0) begin
          m_blk[k]--;
          m_mem[k] = 0;
          m_spk[k] = 0;
        end else begin
          s = om[k] - om[k] / (1 << LS) + inp;
          if (s > MAXV) s = MAXV;
          if (bus.threshold != 0 && s >= int'(bus.threshold)) begin
            m_spk[k] = 1; m_mem[k] = 0; m_blk[k] = RF;
          end else begin
            m_spk[k] = 0; m_mem[k] = s;
          end
        end
      end
      if (clr != 0)                          m_cnt[k] = 0;
      else if (m_spk[k] != 0 && m_cnt[k] < 65535) m_cnt[k]++;
    end
    m_spkvec = 0;
    for (int k = 0; k < NN; k++) m_spkvec |= (m_spk[k] << k);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("model_spike", int'(bus.spike), m_spkvec);
    chk("model_state_out", int'(bus.state_out), m_so);
`ifdef LIF_SPIKE_COUNT_EN
    chk("model_spike_cnt", int'(bus.spike_cnt), m_cnto);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drive(input bit en, input int cur, input int thr, input int sel);
    bus.en         = en;
    bus.current_in = W'(cur);
    bus.threshold  = W'(thr);
    bus.sel        = 1'(sel);
  endtask

  typedef struct {
    bit rst;
    bit en;
    int cur;
    int thr;
    int sel;
    int exp_spk;
    int exp_so;
  } vec_t;

  vec_t tbl[$];

  initial begin
    drive(1'b0, 0, 0, 0);
`ifdef LIF_SPIKE_COUNT_EN
    bus.cnt_clr = 1'b0;
`endif
    model_reset();
    #2;
    chk("reset_spike", int'(bus.spike), 0);
    chk("reset_state_out", int'(bus.state_out), 0);
    #10;
    rst_n = 1'b1;

    // Integrate/fire plus chain hop: membrane 120, 180, fire, 2 refractory edges, 120 again.
    tbl.push_back('{1, 1, 120, 200, 0, 0, 0});
    tbl.push_back('{0, 1, 120, 200, 0, 0, 120});
    tbl.push_back('{0, 1, 120, 200, 0, 1, 180});
    tbl.push_back('{0, 1, 120, 200, 0, 2, 0});
    tbl.push_back('{0, 1, 120, 200, 0, 0, 0});
    tbl.push_back('{0, 1, 120, 200, 0, 0, 0});
    tbl.push_back('{0, 1, 120, 200, 0, 0, 120});
    tbl.push_back('{0, 1, 120, 200, 0, 1, 180});
    tbl.push_back('{0, 1, 120, 200, 0, 2, 0});
    // Saturation with firing disabled.
    tbl.push_back('{1, 1, 255, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 255, 0, 0, 0, 255});
    tbl.push_back('{0, 1, 255, 0, 0, 0, 255});
    tbl.push_back('{0, 1, 255, 0, 0, 0, 255});
    // Enable gating at membrane 180, then fire on the first enabled edge.
    tbl.push_back('{1, 1, 120, 200, 0, 0, 0});
    tbl.push_back('{0, 1, 120, 200, 0, 0, 120});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 120, 200, 0, 0, 180});
    tbl.push_back('{0, 1, 120, 200, 0, 1, 180});
    tbl.push_back('{0, 1, 120, 200, 0, 2, 0});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].en, tbl[i].cur, tbl[i].thr, tbl[i].sel);
      step();
      chk($sformatf("tbl%0d_spike", i), int'(bus.spike), tbl[i].exp_spk);
      chk($sformatf("tbl%0d_state_out", i), int'(bus.state_out), tbl[i].exp_so);
    end

    // Async reset with membrane 150 visible on state_out.
    do_reset();
    drive(1'b1, 100, 0, 0);
    step(); step();
    drive(1'b0, 100, 0, 0);
    step();
    chk("pre_reset_state_out", int'(bus.state_out), 150);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state_out", int'(bus.state_out), 0);
    chk("async_reset_spike", int'(bus.spike), 0);
    #1 rst_n = 1'b1;
    model_reset();
    step();
    chk("post_reset_hold", int'(bus.state_out), 0);

    // Reset while a spike is high: no pulse survives.
    do_reset();
    drive(1'b1, 120, 200, 0);
    step(); step(); step();
    chk("spike_before_reset", int'(bus.spike), 1);
    rst_n = 1'b0;
    #1;
    chk("spike_cleared_by_reset", int'(bus.spike), 0);
    #1 rst_n = 1'b1;
    model_reset();
    step();
    chk("no_pending_spike", int'(bus.spike), 0);

`ifdef LIF_SPIKE_COUNT_EN
    // Four spikes at edges 3/8/13/18, count visible one edge later; clear beats spike at edge 23.
    do_reset();
    drive(1'b1, 120, 200, 0);
    for (int i = 0; i < 19; i++) step();
    chk("spike_cnt_four", int'(bus.spike_cnt), 4);
    for (int i = 0; i < 3; i++) step();
    bus.cnt_clr = 1'b1;
    step();
    chk("clr_edge_spike", int'(bus.spike), 1);
    bus.cnt_clr = 1'b0;
    step();
    chk("spike_cnt_clr_wins", int'(bus.spike_cnt), 0);
`endif

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) != 0,
            ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255),
            $urandom_range(0, 1));
`ifdef LIF_SPIKE_COUNT_EN
      bus.cnt_clr = ($urandom_range(0, 31) == 0);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
